// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: pixel format,
// sprite descriptor layout and a multi-hot helper for collision detection.
package sprite_pkg;

   localparam logic [11:0] KEY_DEFAULT = 12'h428;
   localparam int PIX_W       = 12;
   localparam int XW_DEF      = 10;
   localparam int YW_DEF      = 9;
   localparam int AW_DEF      = 14;
   localparam int NUM_SPR_DEF = 8;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef struct packed {
      logic              en;
      logic [XW_DEF-1:0] x;
      logic [YW_DEF-1:0] y;
      logic [XW_DEF-1:0] w;
      logic [YW_DEF-1:0] h;
   } spr_desc_t;

   // True when two or more bits are set.
   function automatic logic multi_hot(input logic [31:0] v);
      return (v & (v - 32'd1)) != 32'd0;
   endfunction

endpackage

// File: rtl/sprite_hit_addr.sv
// One sprite channel: frame-start shadow descriptor, hit test against the
// incoming coordinate and registered ROM address (stage 1).
module sprite_hit_addr
   import sprite_pkg::*;
#(
   parameter int XW = 10,
   parameter int YW = 9,
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_start,
   input  logic          pix_req,
   input  logic [XW-1:0] col,
   input  logic [YW-1:0] row,
   input  logic          en,
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  logic [XW-1:0] w,
   input  logic [YW-1:0] h,
   output logic [AW-1:0] addr,
   output logic          hit
);

   localparam int PW = (AW > XW + YW) ? AW : XW + YW;

   logic          en_reg;
   logic [XW-1:0] x_reg;
   logic [XW-1:0] w_reg;
   logic [YW-1:0] y_reg;
   logic [YW-1:0] h_reg;

   logic [XW:0]   x_end;
   logic [YW:0]   y_end;
   logic [XW-1:0] dx;
   logic [YW-1:0] dy;
   logic [PW-1:0] lin;
   logic          hit_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         en_reg <= 1'b0;
         x_reg  <= '0;
         y_reg  <= '0;
         w_reg  <= '0;
         h_reg  <= '0;
      end else if (frame_start) begin
         en_reg <= en;
         x_reg  <= x;
         y_reg  <= y;
         w_reg  <= w;
         h_reg  <= h;
      end
   end

   // End bounds carry one extra bit so a sprite hanging off the right or
   // bottom edge cannot wrap around and hit near coordinate 0.
   always_comb begin
      x_end    = {1'b0, x_reg} + {1'b0, w_reg};
      y_end    = {1'b0, y_reg} + {1'b0, h_reg};
      hit_next = pix_req && en_reg
                 && (col >= x_reg) && ({1'b0, col} < x_end)
                 && (row >= y_reg) && ({1'b0, row} < y_end);
      dx       = col - x_reg;
      dy       = row - y_reg;
      lin      = PW'(dy) * PW'(w_reg) + PW'(dx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr <= '0;
         hit  <= 1'b0;
      end else begin
         hit  <= hit_next;
         addr <= hit_next ? AW'(lin) : '0;
      end
   end

endmodule

// File: rtl/sprite_compositor.sv
// Pipelined sprite compositor: per-channel hit/address engines, colour-key
// transparency, index priority, overlay select and collision accumulation.
module sprite_compositor
   import sprite_pkg::*;
#(
   parameter int          NUM_SPR = 8,
   parameter int          XW      = 10,
   parameter int          YW      = 9,
   parameter int          AW      = 14,
   parameter logic [11:0] KEY     = KEY_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     frame_start,
   input  logic                     pix_req,
   input  logic [XW-1:0]            col_in,
   input  logic [YW-1:0]            row_in,
   input  logic [NUM_SPR-1:0]       spr_en,
   input  logic [NUM_SPR*XW-1:0]    spr_x,
   input  logic [NUM_SPR*YW-1:0]    spr_y,
   input  logic [NUM_SPR*XW-1:0]    spr_w,
   input  logic [NUM_SPR*YW-1:0]    spr_h,
   output logic [NUM_SPR*AW-1:0]    spr_addr,
   input  logic [NUM_SPR*12-1:0]    spr_data,
   input  logic [11:0]              bg_data,
   input  logic                     ovl_en,
   input  logic [11:0]              ovl_data,
   output logic [11:0]              pix_out,
   output logic                     pix_valid,
   output logic [$clog2(NUM_SPR):0] top_id,
   output logic [NUM_SPR-1:0]       coll_flags
);

   localparam int IDW = $clog2(NUM_SPR) + 1;

   logic [NUM_SPR-1:0] hit1;
   logic [NUM_SPR-1:0] hit2;
   logic [NUM_SPR-1:0] opaque;
   logic [NUM_SPR-1:0] coll_event;
   logic [NUM_SPR-1:0] acc_reg;
   logic               valid1;
   logic               valid2;
   logic               ovl1;
   logic               ovl2;
   pixel_t             win_pix;
   logic [IDW-1:0]     win_id;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SPR; gi++) begin : g_chan
         sprite_hit_addr #(
            .XW (XW),
            .YW (YW),
            .AW (AW)
         ) u_hit (
            .clk         (clk),
            .rst         (rst),
            .frame_start (frame_start),
            .pix_req     (pix_req),
            .col         (col_in),
            .row         (row_in),
            .en          (spr_en[gi]),
            .x           (spr_x[gi*XW +: XW]),
            .y           (spr_y[gi*YW +: YW]),
            .w           (spr_w[gi*XW +: XW]),
            .h           (spr_h[gi*YW +: YW]),
            .addr        (spr_addr[gi*AW +: AW]),
            .hit         (hit1[gi])
         );

         assign opaque[gi] = hit2[gi] && (spr_data[gi*12 +: 12] != KEY);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         valid1 <= 1'b0;
         ovl1   <= 1'b0;
         valid2 <= 1'b0;
         ovl2   <= 1'b0;
         hit2   <= '0;
      end else begin
         valid1 <= pix_req;
         ovl1   <= ovl_en;
         valid2 <= valid1;
         ovl2   <= ovl1;
         hit2   <= hit1;
      end
   end

   // Later channels overwrite earlier ones, so the highest opaque index wins;
   // the overlay suppresses every sprite.
   always_comb begin
      win_pix = ovl2 ? ovl_data : bg_data;
      win_id  = '0;
      for (int i = 0; i < NUM_SPR; i++) begin
         if (opaque[i] && !ovl2) begin
            win_pix = spr_data[i*12 +: 12];
            win_id  = IDW'(i + 1);
         end
      end
      coll_event = multi_hot(32'(opaque)) ? opaque : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_out    <= '0;
         top_id     <= '0;
         pix_valid  <= 1'b0;
         acc_reg    <= '0;
         coll_flags <= '0;
      end else begin
         pix_valid <= valid2;
         if (valid2) begin
            pix_out <= win_pix;
            top_id  <= win_id;
         end
         if (frame_start) begin
            coll_flags <= acc_reg | coll_event;
            acc_reg    <= '0;
         end else begin
            acc_reg    <= acc_reg | coll_event;
         end
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: expected pixels are queued as
// requests are driven and compared when pix_valid comes out.
module tb_sprite_compositor;

   logic         clk = 1'b0;
   logic         rst;
   logic         frame_start;
   logic         pix_req;
   logic [9:0]   col_in;
   logic [8:0]   row_in;
   logic [7:0]   spr_en;
   logic [79:0]  spr_x;
   logic [71:0]  spr_y;
   logic [79:0]  spr_w;
   logic [71:0]  spr_h;
   logic [111:0] spr_addr;
   logic [95:0]  spr_data;
   logic [11:0]  bg_data;
   logic         ovl_en;
   logic [11:0]  ovl_data;
   logic [11:0]  pix_out;
   logic         pix_valid;
   logic [3:0]   top_id;
   logic [7:0]   coll_flags;

   int checks   = 0;
   int failures = 0;

   // live descriptors driven to the DUT, and the bench's own shadow copy
   logic [7:0]  len;
   logic [9:0]  lx[8];
   logic [9:0]  lw[8];
   logic [8:0]  ly[8];
   logic [8:0]  lh[8];
   logic [7:0]  sen;
   int          sx[8];
   int          sy[8];
   int          sw[8];
   int          sh[8];
   logic [11:0] rom_val[8];
   logic [11:0] bg_val;
   logic [11:0] ovl_val;
   logic [7:0]  acc;
   logic [7:0]  coll_exp;
   logic [15:0] exp_q[$];
   logic [15:0] exp_word;
   logic [11:0] last_px;

   sprite_compositor dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .pix_req     (pix_req),
      .col_in      (col_in),
      .row_in      (row_in),
      .spr_en      (spr_en),
      .spr_x       (spr_x),
      .spr_y       (spr_y),
      .spr_w       (spr_w),
      .spr_h       (spr_h),
      .spr_addr    (spr_addr),
      .spr_data    (spr_data),
      .bg_data     (bg_data),
      .ovl_en      (ovl_en),
      .ovl_data    (ovl_data),
      .pix_out     (pix_out),
      .pix_valid   (pix_valid),
      .top_id      (top_id),
      .coll_flags  (coll_flags)
   );

   always #5 clk = ~clk;

   always_comb begin
      spr_x  = '0;
      spr_y  = '0;
      spr_w  = '0;
      spr_h  = '0;
      spr_en = len;
      for (int i = 0; i < 8; i++) begin
         spr_x[i*10 +: 10] = lx[i];
         spr_w[i*10 +: 10] = lw[i];
         spr_y[i*9 +: 9]   = ly[i];
         spr_h[i*9 +: 9]   = lh[i];
      end
   end

   assign bg_data  = bg_val;
   assign ovl_data = ovl_val;

   // ROM model: one-cycle registered read
   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) spr_data[i*12 +: 12] <= rom_val[i];
   end

   // scoreboard consumer
   always @(negedge clk) begin
      if (!rst && pix_valid) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL unexpected_valid got pix=%h id=%0d required no output", pix_out, top_id);
         end else begin
            exp_word = exp_q.pop_front();
            if ({top_id, pix_out} !== exp_word) begin
               failures = failures + 1;
               $display("FAIL pixel got id=%0d pix=%h required id=%0d pix=%h",
                        top_id, pix_out, exp_word[15:12], exp_word[11:0]);
            end else begin
               $display("pixel id=%0d pix=%h ok", top_id, pix_out);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic void model(input int col, input int row, input logic ovl,
                                 output logic [11:0] px, output logic [3:0] id,
                                 output logic [7:0] opq);
      px  = ovl ? ovl_val : bg_val;
      id  = '0;
      opq = '0;
      for (int i = 0; i < 8; i++) begin
         if (sen[i] && col >= sx[i] && col <= sx[i] + sw[i] - 1 &&
             row >= sy[i] && row <= sy[i] + sh[i] - 1 && rom_val[i] != 12'h428) begin
            opq[i] = 1'b1;
            if (!ovl) begin
               px = rom_val[i];
               id = 4'(i + 1);
            end
         end
      end
   endfunction

   task automatic latch_shadow();
      for (int i = 0; i < 8; i++) begin
         sen[i] = len[i];
         sx[i]  = int'(lx[i]);
         sy[i]  = int'(ly[i]);
         sw[i]  = int'(lw[i]);
         sh[i]  = int'(lh[i]);
      end
   endtask

   task automatic clear_shadow();
      sen = '0;
      for (int i = 0; i < 8; i++) begin
         sx[i] = 0; sy[i] = 0; sw[i] = 0; sh[i] = 0;
      end
   endtask

   task automatic queue_pixel(input int col, input int row, input logic ovl);
      logic [11:0] px;
      logic [3:0]  id;
      logic [7:0]  opq;
      model(col, row, ovl, px, id, opq);
      exp_q.push_back({id, px});
      last_px = px;
      if ($countones(opq) >= 2) acc = acc | opq;
      pix_req = 1'b1;
      col_in  = col[9:0];
      row_in  = row[8:0];
      ovl_en  = ovl;
   endtask

   task automatic send(input int col, input int row, input logic ovl);
      queue_pixel(col, row, ovl);
      @(posedge clk); #1;
      pix_req = 1'b0;
   endtask

   // pixel request coinciding with frame_start: uses the old shadow
   task automatic send_with_frame(input int col, input int row, input logic ovl);
      coll_exp = acc;
      acc      = '0;
      queue_pixel(col, row, ovl);
      latch_shadow();
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      pix_req     = 1'b0;
   endtask

   task automatic do_frame();
      coll_exp = acc;
      acc      = '0;
      latch_shadow();
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
   endtask

   task automatic set_spr(input int i, input int x, input int y, input int w, input int h,
                          input logic [11:0] rom);
      len[i]     = 1'b1;
      lx[i]      = 10'(x);
      ly[i]      = 9'(y);
      lw[i]      = 10'(w);
      lh[i]      = 9'(h);
      rom_val[i] = rom;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks = checks + 5;
      if (pix_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b required 0", pix_valid); end
      if (pix_out !== 12'h000) begin failures++; $display("FAIL reset_pix got %h required 000", pix_out); end
      if (top_id !== 4'd0) begin failures++; $display("FAIL reset_id got %0d required 0", top_id); end
      if (spr_addr !== '0) begin failures++; $display("FAIL reset_addr got %h required 0", spr_addr); end
      if (coll_flags !== 8'h00) begin failures++; $display("FAIL reset_coll got %h required 00", coll_flags); end
      rst = 1'b0;
      // descriptor is live but not yet latched: sprite must stay hidden
      bg_val = 12'h123;
      set_spr(0, 100, 50, 47, 41, 12'h0F0);
      send(100, 50, 1'b0);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL drain_reset pending=%0d required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_single();
      do_frame();
      send(100, 50, 1'b0);
      checks++;
      if (spr_addr[13:0] !== 14'd0) begin failures++; $display("FAIL addr_origin got %0d required 0", spr_addr[13:0]); end
      @(posedge clk); #1;
      checks++;
      if (pix_valid !== 1'b0) begin failures++; $display("FAIL latency_early got valid=%b required 0", pix_valid); end
      @(posedge clk); #1;
      checks++;
      if (pix_valid !== 1'b1 || pix_out !== 12'h0F0 || top_id !== 4'd1) begin
         failures++;
         $display("FAIL latency_3 got valid=%b pix=%h id=%0d required 1 0f0 1", pix_valid, pix_out, top_id);
      end
      send(147, 90, 1'b0);
      checks++;
      if (spr_addr[13:0] !== 14'd0) begin failures++; $display("FAIL addr_miss got %0d required 0", spr_addr[13:0]); end
      send(146, 91, 1'b0);
      send(146, 90, 1'b0);
      checks++;
      if (spr_addr[13:0] !== 14'd1926) begin failures++; $display("FAIL addr_corner got %0d required 1926", spr_addr[13:0]); end
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL drain_single pending=%0d required 0", exp_q.size()); exp_q.delete(); end
      checks++;
      if (pix_out !== last_px || pix_out !== 12'h0F0) begin failures++; $display("FAIL hold_pix got %h required 0f0", pix_out); end
   endtask

   task automatic test_key();
      set_spr(2, 300, 300, 10, 10, 12'h428);
      do_frame();
      send(305, 305, 1'b0);
      send(100, 50, 1'b0);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL drain_key pending=%0d required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_priority();
      set_spr(1, 195, 195, 10, 10, 12'h00F);
      set_spr(3, 198, 198, 10, 10, 12'hF00);
      do_frame();
      checks++;
      if (coll_flags !== coll_exp) begin failures++; $display("FAIL coll_before got %b required %b", coll_flags, coll_exp); end
      send(200, 200, 1'b0);
      send(196, 196, 1'b0);
      send(205, 205, 1'b0);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL drain_prio pending=%0d required 0", exp_q.size()); exp_q.delete(); end
      do_frame();
      checks++;
      if (coll_flags !== 8'b0000_1010) begin failures++; $display("FAIL coll_flags got %b required 00001010", coll_flags); end
      send(196, 196, 1'b0);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      do_frame();
      checks++;
      if (coll_flags !== 8'b0000_0000) begin failures++; $display("FAIL coll_clean got %b required 00000000", coll_flags); end
   endtask

   task automatic test_shadow();
      lx[0] = 10'd300;
      send(100, 50, 1'b0);
      send(300, 50, 1'b0);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      do_frame();
      send(100, 50, 1'b0);
      send(300, 50, 1'b0);
      lx[0] = 10'd100;
      send_with_frame(300, 50, 1'b0);
      send(100, 50, 1'b0);
      send(300, 50, 1'b0);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL drain_shadow pending=%0d required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_overlay_edge();
      ovl_val = 12'hABC;
      send(100, 50, 1'b1);
      send(500, 400, 1'b1);
      set_spr(4, 1000, 0, 47, 20, 12'h0AA);
      do_frame();
      for (int c = 0; c < 24; c++) send(c, 5, 1'b0);
      send(1000, 5, 1'b0);
      checks++;
      if (spr_addr[4*14 +: 14] !== 14'd235) begin failures++; $display("FAIL addr_edge_lo got %0d required 235", spr_addr[4*14 +: 14]); end
      send(1023, 5, 1'b0);
      checks++;
      if (spr_addr[4*14 +: 14] !== 14'd258) begin failures++; $display("FAIL addr_edge_hi got %0d required 258", spr_addr[4*14 +: 14]); end
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL drain_edge pending=%0d required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_reset_flight();
      int bad;
      send(100, 50, 1'b0);
      send(1000, 5, 1'b0);
      pix_req = 1'b1;
      col_in  = 10'd200;
      row_in  = 9'd200;
      rst     = 1'b1;
      @(posedge clk); #1;
      pix_req = 1'b0;
      exp_q.delete();
      acc      = '0;
      coll_exp = '0;
      clear_shadow();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks = checks + 4;
      if (pix_out !== 12'h000) begin failures++; $display("FAIL flight_pix got %h required 000", pix_out); end
      if (top_id !== 4'd0) begin failures++; $display("FAIL flight_id got %0d required 0", top_id); end
      if (spr_addr !== '0) begin failures++; $display("FAIL flight_addr got %h required 0", spr_addr); end
      if (coll_flags !== 8'h00) begin failures++; $display("FAIL flight_coll got %h required 00", coll_flags); end
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (pix_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL flight_valid got %0d valid cycles required 0", bad); end
      send(100, 50, 1'b0);
      send(1010, 5, 1'b0);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL drain_flight pending=%0d required 0", exp_q.size()); exp_q.delete(); end
   endtask

   initial begin
      rst         = 1'b1;
      frame_start = 1'b0;
      pix_req     = 1'b0;
      col_in      = '0;
      row_in      = '0;
      ovl_en      = 1'b0;
      len         = '0;
      bg_val      = '0;
      ovl_val     = '0;
      acc         = '0;
      coll_exp    = '0;
      last_px     = '0;
      for (int i = 0; i < 8; i++) begin
         lx[i] = '0; ly[i] = '0; lw[i] = '0; lh[i] = '0;
         rom_val[i] = 12'h428;
      end
      clear_shadow();

      test_reset();
      test_single();
      test_key();
      test_priority();
      test_shadow();
      test_overlay_edge();
      test_reset_flight();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised, pipelined pixel compositor for the VGA path. It replaces the hand-unrolled per-object hit-test and draw chain with a generic engine. For each pixel coordinate from the VGA timing block, it computes a ROM address for each of `NUM_SPR` sprite channels and returns each sprite's pixel. It applies colour-key transparency and a fixed index priority over the background, with an optional full-screen overlay (title/lose screen). Sprite descriptors are double-buffered at frame start, and per-frame sprite-overlap flags are reported for game logic.

## Interface
Parameters:
- `NUM_SPR`, 8: number of sprite channels (1..32)
- `XW`, 10: column coordinate width
- `YW`, 9: row coordinate width
- `AW`, 14: per-sprite ROM address width
- `KEY`, 12'h428: transparent colour key (RGB444)

Ports:
- `clk`  in  1: pixel-domain clock
- `rst`  in  1: synchronous, active-high reset
- `frame_start`  in  1: one-cycle pulse at start of vertical blank
- `pix_req`  in  1: coordinate valid this cycle
- `col_in`  in  XW: pixel column
- `row_in`  in  YW: pixel row
- `spr_en`  in  NUM_SPR: channel enable (live value)
- `spr_x`, `spr_y`  in  NUM_SPR*XW / NUM_SPR*YW: top-left corner, channel i at slice i
- `spr_w`, `spr_h`  in  NUM_SPR*XW / NUM_SPR*YW: sprite width/height in pixels (≥1)
- `spr_addr`  out  NUM_SPR*AW: registered ROM address per channel
- `spr_data`  in  NUM_SPR*12: ROM data, one cycle after `spr_addr`
- `bg_data`  in  12: background pixel, aligned with `spr_data`
- `ovl_en`  in  1: overlay select (sampled with `pix_req`)
- `ovl_data`  in  12: overlay pixel, aligned with `spr_data`
- `pix_out`  out  12: composited pixel
- `pix_valid`  out  1: `pix_out` valid
- `top_id`  out  $clog2(NUM_SPR)+1: winning channel+1, 0 = background/overlay
- `coll_flags`  out  NUM_SPR: per-channel overlap flags for last completed frame

## Operation
- Shadow registers: on `frame_start`, latch all `spr_en/x/y/w/h` into shadows. All compositing uses shadows only. The new values apply to a `pix_req` that arrives the cycle after `frame_start`. A `pix_req` in the same cycle as `frame_start` uses the old values.
- Hit test for channel i: enabled, `x ≤ col ≤ x+w-1` and `y ≤ row ≤ y+h-1`. Evaluate the bounds at XW+1 / YW+1 bits so that `x+w` beyond the screen cannot wrap.
- Address: on a hit, `(row-y)*w + (col-x)`, truncated to AW. On a miss, 0.
- Opaque for channel i: the hit is valid and `spr_data[i] != KEY`.
- Priority: the highest-index opaque channel wins, giving `pix_out` = its data and `top_id` = i+1.
- Fallback when no channel is opaque: `pix_out` = `ovl_data` if `ovl_en`, else `bg_data`, with `top_id` = 0.
- Overlay: when `ovl_en`=1, the overlay also beats all sprites. Output is `ovl_data`, `top_id`=0.
- Collision accumulator: if two or more channels are opaque on the same pixel, OR their bits into the accumulator.
- On `frame_start`: `coll_flags` ← accumulator | same-cycle events, and the accumulator clears to 0.

## Timing
- Stage 0 (cycle T): `pix_req`, coordinates and `ovl_en` are sampled.
- Stage 1 (T+1): `spr_addr` and the hit vector are registered.
- Stage 2 (T+2): `spr_data`, `bg_data` and `ovl_data` are consumed.
- Stage 3 (T+3): `pix_out`, `top_id` and `pix_valid` are registered. Fixed latency is 3 cycles, with throughput of one pixel per cycle and no back-pressure.
- `pix_valid` follows `pix_req` delayed by 3 cycles. When not valid, `pix_out` holds its last value.
- Reset values:
  - `pix_out`=0, `pix_valid`=0, `top_id`=0, `spr_addr`=0, `coll_flags`=0.
  - Shadow enables are 0, so no sprite is drawn until the first `frame_start`.
  - The accumulator is 0.
- Reset mid-stream flushes the pipeline. No `pix_valid` is issued for requests already in flight.

## Structure
- Package `sprite_pkg`:
  - `KEY_DEFAULT`
  - `pixel_t` (12-bit RGB444)
  - `spr_desc_t` struct {en, x, y, w, h}
  - width constants
- Sub-module `sprite_hit_addr`: one per channel via generate. It holds the shadow descriptor, hit compare, address multiply and stage-1 registers.
- Top level: priority mux, overlay select and collision accumulator.

## Test plan
- Single sprite: ch0 at (100,50), 47x41, ROM=0x0F0. Request (100,50) → `spr_addr`=0. Request (146,90) → `spr_addr`=1926. After 3 cycles `pix_out`=0x0F0, `top_id`=1.
- Key transparency: ch2 ROM returns 0x428, `bg_data`=0x123 → `pix_out`=0x123, `top_id`=0.
- Priority and collision:
  - ch1 and ch3 both opaque at (200,200) → `pix_out`=ch3 data, `top_id`=4.
  - After the next `frame_start`, `coll_flags`=0b1010. After a further clean frame, it reads 0.
- Shadowing: change `spr_x[0]` from 100 to 300 mid-frame → the pixel at 100 is still drawn. After `frame_start`, the pixel at 100 is background and the pixel at 300 is drawn.
- Overlay/edge: `ovl_en`=1 with an opaque sprite → `pix_out`=`ovl_data`. Sprite at x=1000, w=47 → no hit at col 0..23 (no wrap).
- Reset: assert `rst` with 3 requests in flight → `pix_valid` stays 0 and all outputs are 0. Sprites stay hidden until `frame_start`.
